// File: rtl/useq_pkg.sv
// Shared definitions for the microprogram sequencer: FSM state encoding,
// next-state select encodings and the default fetch-entry micro-state.
package useq_pkg;

  // Sequencer FSM states. FAULT is only reachable when USEQ_WATCHDOG_EN is defined.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STALL = 3'd2,
    HALT  = 3'd3,
    FAULT = 3'd4
  } useq_state_e;

  // Next-state select field of the control word.
  localparam logic [1:0] NSSEL_DIRECT   = 2'b00;
  localparam logic [1:0] NSSEL_DISPATCH = 2'b01;
  localparam logic [1:0] NSSEL_SECOND   = 2'b10;
  localparam logic [1:0] NSSEL_COND     = 2'b11;

  // Default fetch-entry micro-state.
  localparam int unsigned ENTRY_ST_DEF = 0;

endpackage

// File: rtl/useq_next_addr.sv
// Next micro-address mux. Pure combinational; the sequencer decides whether
// the result is actually loaded into the micro-state register.
module useq_next_addr
  import useq_pkg::*;
#(
  parameter int ST_W = 5
) (
  input  logic [1:0]      nssel,
  input  logic [ST_W-1:0] dbin,
  input  logic [ST_W-1:0] ibin,
  input  logic [ST_W-1:0] sbin,
  input  logic            zero,
  output logic [ST_W-1:0] nx
);

  // Select the branch target; COND replaces the LSB of dbin with the ALU zero flag.
  always_comb begin
    nx = dbin;
    case (nssel)
      NSSEL_DIRECT:   nx = dbin;
      NSSEL_DISPATCH: nx = ibin;
      NSSEL_SECOND:   nx = sbin;
      NSSEL_COND:     nx = {dbin[ST_W-1:1], zero};
      default:        nx = dbin;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: owns the micro-state register (control store address),
// advances it from the control word's next-state select, and wraps run/stall/halt
// sequencing around the memory handshake.
// Optional feature macro: USEQ_WATCHDOG_EN (stall watchdog and FAULT state).
//
// Handshake: when the control word asserts cw_wait, the sequencer advances only on
// a cycle where mem_ready is 1; mem_ready is sampled on the rising clk edge and a
// transfer completes on exactly that edge. cw_* must be held stable while stalled.
module micro_sequencer
  import useq_pkg::*;
#(
  parameter int              ST_W     = 5,
  parameter logic [ST_W-1:0] ENTRY_ST = ST_W'(ENTRY_ST_DEF),
  parameter int              CNT_W    = 16,
  parameter int              WD_LIMIT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ST_W-1:0]  ibin,
  input  logic [ST_W-1:0]  sbin,
  input  logic             zero,
  input  logic [1:0]       cw_nssel,
  input  logic [ST_W-1:0]  cw_dbin,
  input  logic             cw_wait,
  input  logic             cw_halt,
  input  logic             mem_ready,
  output logic [ST_W-1:0]  ustate,
  output logic             cw_valid,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_RUN   = RUN;
  localparam logic [2:0] S_STALL = STALL;
  localparam logic [2:0] S_HALT  = HALT;
  localparam logic [2:0] S_FAULT = FAULT;

  logic [2:0]      state;
  logic [2:0]      state_nx;
  logic [ST_W-1:0] nx;
  logic            restart;
  logic            advance;

`ifdef USEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_trip;
  assign wd_trip = (wd_cnt == WD_W'(WD_LIMIT - 1));
`endif

  useq_next_addr #(.ST_W(ST_W)) u_next_addr (
    .nssel (cw_nssel),
    .dbin  (cw_dbin),
    .ibin  (ibin),
    .sbin  (sbin),
    .zero  (zero),
    .nx    (nx)
  );

  // Next-state decode: start restarts from any state; in RUN halt beats wait beats advance.
  always_comb begin
    state_nx = state;
    restart  = 1'b0;
    advance  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          restart  = 1'b1;
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (start) begin
          restart  = 1'b1;
          state_nx = S_RUN;
        end else if (cw_halt) begin
          state_nx = S_HALT;
        end else if (cw_wait && !mem_ready) begin
          state_nx = S_STALL;
        end else begin
          advance  = 1'b1;
          state_nx = S_RUN;
        end
      end
      S_STALL: begin
        if (start) begin
          restart  = 1'b1;
          state_nx = S_RUN;
        end else if (mem_ready) begin
          advance  = 1'b1;
          state_nx = S_RUN;
        end
`ifdef USEQ_WATCHDOG_EN
        else if (wd_trip) begin
          state_nx = S_FAULT;
        end
`endif
      end
      S_HALT: begin
        if (start) begin
          restart  = 1'b1;
          state_nx = S_RUN;
        end
      end
`ifdef USEQ_WATCHDOG_EN
      S_FAULT: begin
        if (start) begin
          restart  = 1'b1;
          state_nx = S_RUN;
        end
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // State, micro-address and retired-dispatch counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ustate    <= ENTRY_ST;
      instr_cnt <= '0;
    end else begin
      state <= state_nx;
      if (restart) begin
        ustate <= ENTRY_ST;
      end else if (advance) begin
        ustate <= nx;
        if (cw_nssel == NSSEL_DISPATCH) begin
          instr_cnt <= instr_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef USEQ_WATCHDOG_EN
  // Stall watchdog: cleared on entry to STALL, counts each cycle spent stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state != S_STALL) begin
      wd_cnt <= '0;
    end else if (!wd_trip) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`endif

  assign busy      = (state == S_RUN) || (state == S_STALL);
  assign cw_valid  = busy;
  assign halted    = (state == S_HALT);
  assign fault     = (state == S_FAULT);
  assign state_dbg = state;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer (ST_W=5, CNT_W=4 so counter wrap is reachable).
module tb_micro_sequencer;
  import useq_pkg::*;

  localparam int ST_W  = 5;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [ST_W-1:0]  ibin;
  logic [ST_W-1:0]  sbin;
  logic             zero;
  logic [1:0]       cw_nssel;
  logic [ST_W-1:0]  cw_dbin;
  logic             cw_wait;
  logic             cw_halt;
  logic             mem_ready;
  logic [ST_W-1:0]  ustate;
  logic             cw_valid;
  logic             busy;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] instr_cnt;
  logic [2:0]       state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  micro_sequencer #(
    .ST_W     (ST_W),
    .ENTRY_ST (5'd0),
    .CNT_W    (CNT_W),
    .WD_LIMIT (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ibin      (ibin),
    .sbin      (sbin),
    .zero      (zero),
    .cw_nssel  (cw_nssel),
    .cw_dbin   (cw_dbin),
    .cw_wait   (cw_wait),
    .cw_halt   (cw_halt),
    .mem_ready (mem_ready),
    .ustate    (ustate),
    .cw_valid  (cw_valid),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault),
    .instr_cnt (instr_cnt),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       start;
    logic [1:0] nssel;
    logic [4:0] dbin;
    logic [4:0] ibin;
    logic [4:0] sbin;
    logic       zero;
    logic       wt;
    logic       hlt;
    logic       rdy;
    logic [4:0] exp_ustate;
    logic       exp_busy;
    logic       exp_halted;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  // Driver tasks
  task automatic drive(input logic st, input logic [1:0] ns, input logic [4:0] db,
                       input logic [4:0] ib, input logic [4:0] sb, input logic z,
                       input logic wt, input logic hl, input logic rd);
    start = st; cw_nssel = ns; cw_dbin = db; ibin = ib; sbin = sb;
    zero = z; cw_wait = wt; cw_halt = hl; mem_ready = rd;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [4:0] eu, input logic eb,
                            input logic eh, input logic ef, input logic [3:0] ec);
    check({name, " ustate"}, 32'(ustate), 32'(eu));
    check({name, " busy"}, 32'(busy), 32'(eb));
    check({name, " cw_valid"}, 32'(cw_valid), 32'(eb));
    check({name, " halted"}, 32'(halted), 32'(eh));
    check({name, " fault"}, 32'(fault), 32'(ef));
    check({name, " instr_cnt"}, 32'(instr_cnt), 32'(ec));
  endtask

  initial begin
    // Table of {inputs, expected outputs after the edge}, starting from reset.
    vecs.push_back('{"start",       1,2'b00,5'd0,    5'd0, 5'd0,0,0,0,0, 5'd0,    1,0,4'd0});
    vecs.push_back('{"direct7",     0,2'b00,5'd7,    5'd0, 5'd0,0,0,0,0, 5'd7,    1,0,4'd0});
    vecs.push_back('{"dispatch12",  0,2'b01,5'd0,    5'd12,5'd0,0,0,0,0, 5'd12,   1,0,4'd1});
    vecs.push_back('{"second3",     0,2'b10,5'd0,    5'd0, 5'd3,0,0,0,0, 5'd3,    1,0,4'd1});
    vecs.push_back('{"cond_z1",     0,2'b11,5'b10100,5'd0, 5'd0,1,0,0,0, 5'b10101,1,0,4'd1});
    vecs.push_back('{"cond_z0",     0,2'b11,5'b10100,5'd0, 5'd0,0,0,0,0, 5'b10100,1,0,4'd1});
    vecs.push_back('{"dispatch5",   0,2'b01,5'd0,    5'd5, 5'd0,0,0,0,0, 5'd5,    1,0,4'd2});
    vecs.push_back('{"stall1",      0,2'b00,5'd9,    5'd0, 5'd0,0,1,0,0, 5'd5,    1,0,4'd2});
    vecs.push_back('{"stall2",      0,2'b00,5'd9,    5'd0, 5'd0,0,1,0,0, 5'd5,    1,0,4'd2});
    vecs.push_back('{"stall3",      0,2'b00,5'd9,    5'd0, 5'd0,0,1,0,0, 5'd5,    1,0,4'd2});
    vecs.push_back('{"ready",       0,2'b00,5'd9,    5'd0, 5'd0,0,1,0,1, 5'd9,    1,0,4'd2});
    vecs.push_back('{"wait_ready",  0,2'b00,5'd4,    5'd0, 5'd0,0,1,0,1, 5'd4,    1,0,4'd2});
    vecs.push_back('{"halt_wait",   0,2'b00,5'd9,    5'd0, 5'd0,0,1,1,0, 5'd4,    0,1,4'd2});
    vecs.push_back('{"halt_hold",   0,2'b01,5'd9,    5'd6, 5'd0,0,0,0,1, 5'd4,    0,1,4'd2});
    vecs.push_back('{"halt_start",  1,2'b00,5'd9,    5'd0, 5'd0,0,0,0,0, 5'd0,    1,0,4'd2});
    vecs.push_back('{"start_beats", 1,2'b01,5'd9,    5'd8, 5'd0,0,1,1,0, 5'd0,    1,0,4'd2});
    vecs.push_back('{"stall_disp",  0,2'b01,5'd0,    5'd17,5'd0,0,1,0,0, 5'd0,    1,0,4'd2});
    vecs.push_back('{"stall_start", 1,2'b01,5'd0,    5'd17,5'd0,0,1,0,0, 5'd0,    1,0,4'd2});

    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_outs("reset", 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    check("reset state", 32'(state_dbg), 32'(IDLE));

    // IDLE ignores the control word until start.
    drive(1'b0, 2'b00, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check_outs("idle_ignore", 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].nssel, vecs[i].dbin, vecs[i].ibin, vecs[i].sbin,
            vecs[i].zero, vecs[i].wt, vecs[i].hlt, vecs[i].rdy);
      step();
      check_outs(vecs[i].name, vecs[i].exp_ustate, vecs[i].exp_busy,
                 vecs[i].exp_halted, 1'b0, vecs[i].exp_cnt);
    end

    // Reset mid-stall: back to IDLE with no partial advance, counter cleared.
    drive(1'b0, 2'b01, 5'd0, 5'd21, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("pre_rst stalled", 32'(state_dbg), 32'(STALL));
    rst = 1'b1;
    mem_ready = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    check_outs("rst_in_stall", 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    check("rst_in_stall state", 32'(state_dbg), 32'(IDLE));

    // Counter wrap at CNT_W=4: 15 dispatches reach 15, the 16th wraps to 0.
    drive(1'b1, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    for (int k = 1; k <= 15; k++) begin
      drive(1'b0, 2'b01, 5'd0, 5'(k), 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    check_outs("cnt15", 5'd15, 1'b1, 1'b0, 1'b0, 4'd15);
    drive(1'b0, 2'b01, 5'd0, 5'd30, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("cnt_wrap", 5'd30, 1'b1, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 2'b01, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("cnt_after_wrap", 5'd2, 1'b1, 1'b0, 1'b0, 4'd1);
    // Restart keeps the counter.
    drive(1'b1, 2'b01, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("restart_keeps_cnt", 5'd0, 1'b1, 1'b0, 1'b0, 4'd1);

    // Long stall: watchdog trips after 64 stall cycles, otherwise waits forever.
    drive(1'b0, 2'b00, 5'd11, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("long_stall entry", 32'(state_dbg), 32'(STALL));
    begin
      int cycles;
      cycles = 0;
      while (!fault && cycles < 100) begin
        step();
        cycles++;
      end
`ifdef USEQ_WATCHDOG_EN
      check("wd cycles to fault", 32'(cycles), 32'd64);
      check_outs("wd_fault", 5'd0, 1'b0, 1'b0, 1'b1, 4'd1);
      drive(1'b1, 2'b00, 5'd11, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      check_outs("wd_start_clears", 5'd0, 1'b1, 1'b0, 1'b0, 4'd1);
      check("wd_start state", 32'(state_dbg), 32'(RUN));
`else
      check("no_wd still stalled", 32'(state_dbg), 32'(STALL));
      check_outs("no_wd hold", 5'd0, 1'b1, 1'b0, 1'b0, 4'd1);
      mem_ready = 1'b1;
      step();
      check_outs("no_wd release", 5'd11, 1'b1, 1'b0, 1'b0, 4'd1);
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
